// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Result is {remainder, quotient}; ready_o marks result_o valid until start_i drops.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   rem_r;
    logic [DATA_W-1:0]   quo_r;
    logic [DATA_W-1:0]   divisor_r;
    logic                sign1_r;
    logic                sign2_r;
    logic                signed_r;
    logic                ready_r;
    logic [2*DATA_W-1:0] result_r;

    logic [DATA_W:0]     partial_s;
    logic [DATA_W:0]     diff_s;
    logic [DATA_W-1:0]   rem_nxt_s;
    logic [DATA_W-1:0]   quo_nxt_s;
    logic [DATA_W-1:0]   rem_fix_s;
    logic [DATA_W-1:0]   quo_fix_s;
    logic                op1_neg_s;
    logic                op2_neg_s;

    // Two's complement negation; the most negative value wraps onto itself.
    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return ~v + DATA_W'(1'b1);
    endfunction

    // Magnitude of an operand, taken only when it is a negative signed value.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic            neg);
        return neg ? negate(v) : v;
    endfunction

    assign op1_neg_s = signed_div_i & opdata1_i[DATA_W-1];
    assign op2_neg_s = signed_div_i & opdata2_i[DATA_W-1];

    // One restoring step; the partial remainder keeps the bit shifted out of rem.
    always_comb begin
        partial_s = {rem_r, quo_r[DATA_W-1]};
        diff_s    = partial_s - {1'b0, divisor_r};
        if (!diff_s[DATA_W]) begin
            rem_nxt_s = diff_s[DATA_W-1:0];
            quo_nxt_s = {quo_r[DATA_W-2:0], 1'b1};
        end else begin
            rem_nxt_s = partial_s[DATA_W-1:0];
            quo_nxt_s = {quo_r[DATA_W-2:0], 1'b0};
        end
    end

    // Sign restoration applied once all iterations are done.
    always_comb begin
        if (signed_r && (sign1_r != sign2_r)) begin
            quo_fix_s = negate(quo_r);
        end else begin
            quo_fix_s = quo_r;
        end
        if (signed_r && sign1_r) begin
            rem_fix_s = negate(rem_r);
        end else begin
            rem_fix_s = rem_r;
        end
    end

    // Control FSM, working registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_FREE;
            cnt_r     <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            divisor_r <= '0;
            sign1_r   <= 1'b0;
            sign2_r   <= 1'b0;
            signed_r  <= 1'b0;
            ready_r   <= 1'b0;
            result_r  <= '0;
        end else begin
            case (state_r)
                S_FREE: begin
                    ready_r  <= 1'b0;
                    result_r <= '0;
                    if (start_i && !annul_i) begin
                        quo_r     <= magnitude(opdata1_i, op1_neg_s);
                        divisor_r <= magnitude(opdata2_i, op2_neg_s);
                        rem_r     <= '0;
                        cnt_r     <= '0;
                        sign1_r   <= op1_neg_s;
                        sign2_r   <= op2_neg_s;
                        signed_r  <= signed_div_i;
                        state_r   <= (opdata2_i == '0) ? S_BYZERO : S_ON;
                    end else begin
                        state_r   <= S_FREE;
                    end
                end
                S_BYZERO: begin
                    result_r <= '0;
                    if (annul_i) begin
                        ready_r <= 1'b0;
                        state_r <= S_FREE;
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= S_END;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        ready_r  <= 1'b0;
                        result_r <= '0;
                        state_r  <= S_FREE;
                    end else if (cnt_r == CNT_W'(DATA_W)) begin
                        ready_r  <= 1'b1;
                        result_r <= {rem_fix_s, quo_fix_s};
                        state_r  <= S_END;
                    end else begin
                        ready_r  <= 1'b0;
                        result_r <= '0;
                        rem_r    <= rem_nxt_s;
                        quo_r    <= quo_nxt_s;
                        cnt_r    <= cnt_r + CNT_W'(1'b1);
                        state_r  <= S_ON;
                    end
                end
                S_END: begin
                    if (start_i && !annul_i) begin
                        state_r <= S_END;
                    end else begin
                        ready_r  <= 1'b0;
                        result_r <= '0;
                        state_r  <= S_FREE;
                    end
                end
                default: begin
                    ready_r  <= 1'b0;
                    result_r <= '0;
                    state_r  <= S_FREE;
                end
            endcase
        end
    end

    assign ready_o  = ready_r;
    assign result_o = result_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random divides
// compared against a plain-arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div = 1'b0;
    logic [31:0] op1 = 32'd0;
    logic [31:0] op2 = 32'd0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;

    int checks = 0;
    int errors = 0;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: DIV truncates toward zero with remainder taking the dividend's sign.
    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [63:0] exp;
        int n;
        int exp_lat;
        exp     = ref_div(sg, a, b);
        exp_lat = (b == 32'd0) ? 1 : 33;
        @(negedge clk);
        signed_div = sg;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                op1 = $urandom;
                op2 = $urandom;
                signed_div = ~sg;
            end
            if (!ready) check("idle_res", result, 64'd0);
        end while (!ready && n < 40);
        check("latency", 64'(n), 64'(exp_lat));
        check("result", result, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_rdy", {63'd0, ready}, 64'd1);
            check("hold_res", result, exp);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rel_rdy", {63'd0, ready}, 64'd0);
        check("rel_res", result, 64'd0);
    endtask

    initial begin
        logic seen;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", {63'd0, ready}, 64'd0);
        check("rst_res", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, 2);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        run_div(1'b0, 32'd1234, 32'd0, 1);
        run_div(1'b1, 32'h8000_0000, 32'd0, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_div(1'b1, 32'h8000_0000, 32'd1, 0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        run_div(1'b0, 32'd5, 32'hFFFF_FFFF, 0);

        // Annul at E10, then a fresh request accepted at E12.
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd50; op2 = 32'd5; start = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        #1;
        check("annul_rdy", {63'd0, ready}, 64'd0);
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("annul_idle", {63'd0, ready}, 64'd0);
        run_div(1'b0, 32'd9, 32'd3, 0);

        // Reset at E20 aborts the divide.
        @(negedge clk);
        signed_div = 1'b1; op1 = 32'd77; op2 = 32'd3; start = 1'b1;
        @(posedge clk);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_rdy", {63'd0, ready}, 64'd0);
        check("mrst_res", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) seen = 1'b1;
        end
        check("mrst_quiet", {63'd0, seen}, 64'd0);
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 0);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            logic sg;
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if (i % 5 == 1) b = {16'd0, b[15:0]};
            sg = 1'($urandom_range(0, 1));
            run_div(sg, a, b, i % 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
